// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads words from instruction memory
// and hands them to the decoder over a DOR/ack handshake.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  redirect_en,
  input  logic [15:0]           redirect_pc,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_di,
  input  logic [31:0]           mem_do,
  input  logic                  mem_do_ack,
  output logic                  DOR,
  output logic [31:0]           data_out,
  input  logic                  ack_from_next,
  output logic [15:0]           pc_out,
  output logic [15:0]           fetch_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    PRESENT,
    RELEASE
  } state_t;

  localparam logic [15:0] PC_RST = RESET_PC & 16'hFFFC;

  state_t                state_q;
  logic [15:0]           pc_q;
  logic                  mem_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  dor_q;
  logic [31:0]           data_q;
  logic [15:0]           cnt_q;
  logic                  discard_q;
  logic [15:0]           redir_pc;
  logic                  drop;

  assign redir_pc = redirect_pc & 16'hFFFC;
  // A redirect landing on the ack cycle must also kill the stale word.
  assign drop     = discard_q | redirect_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= PC_RST;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      dor_q      <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run) state_q <= FETCH;
        end
        FETCH: begin
          mem_en_q   <= 1'b1;
          mem_addr_q <= pc_q[ADDR_WIDTH+1:2];
          state_q    <= WAIT_MEM;
          if (redirect_en) discard_q <= 1'b1;
        end
        WAIT_MEM: begin
          if (mem_do_ack) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            if (drop) begin
              discard_q <= 1'b0;
              state_q   <= FETCH;
            end else begin
              data_q  <= mem_do;
              dor_q   <= 1'b1;
              state_q <= PRESENT;
            end
          end else if (redirect_en) begin
            discard_q <= 1'b1;
          end
        end
        PRESENT: begin
          if (ack_from_next) begin
            dor_q   <= 1'b0;
            cnt_q   <= cnt_q + 16'd1;
            pc_q    <= pc_q + 16'd4;
            state_q <= RELEASE;
          end else if (redirect_en) begin
            dor_q   <= 1'b0;
            state_q <= FETCH;
          end
        end
        RELEASE: begin
          if (!ack_from_next) state_q <= run ? FETCH : IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (redirect_en) pc_q <= redir_pc;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = 1'b0;
  assign mem_addr    = mem_addr_q;
  assign mem_di      = '0;
  assign DOR         = dor_q;
  assign data_out    = data_q;
  assign pc_out      = pc_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency memory model
// and a scripted decoder.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do = '0;
  logic        mem_do_ack;
  logic        DOR;
  logic [31:0] data_out;
  logic        ack_from_next = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] fetch_count;

  int tests = 0;
  int fails = 0;
  int lat = 1;
  int cnt = 0;
  int viol = 0;
  logic ack_q = 1'b0;
  logic force_ack = 1'b0;
  logic dor_prev = 1'b0;
  logic [9:0] last_addr;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .run(run),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_di(mem_di), .mem_do(mem_do), .mem_do_ack(mem_do_ack),
    .DOR(DOR), .data_out(data_out), .ack_from_next(ack_from_next),
    .pc_out(pc_out), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'b0, a};
  endfunction

  assign mem_do_ack = ack_q | force_ack;

  always @(posedge clk) begin
    if (!reset) begin
      ack_q <= 1'b0;
      cnt   <= 0;
    end else if (mem_en && !ack_q) begin
      if (cnt + 1 >= lat) begin
        ack_q  <= 1'b1;
        mem_do <= word(mem_addr);
        cnt    <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (DOR && !dor_prev && ack_from_next) viol++;
    dor_prev = DOR;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_dor(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_en) last_addr = mem_addr;
      if (DOR) break;
    end
    if (i == 100) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_memen(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_en) break;
    end
    if (i == 100) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic ack_on();
    tick(1);
    ack_from_next = 1'b1;
    tick(1);
    check("dor_drop", {31'b0, DOR}, 32'd0);
  endtask

  initial begin
    tick(2);
    check("rst_dor", {31'b0, DOR}, 32'd0);
    check("rst_mem", {mem_we, mem_en, mem_addr}, 32'd0);
    check("rst_di", mem_di, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_pc", {16'b0, pc_out}, 32'd0);
    check("rst_cnt", {16'b0, fetch_count}, 32'd0);
    reset = 1'b1;
    run = 1'b1;

    // three sequential words, latency 1
    for (int i = 0; i < 3; i++) begin
      wait_dor("t1_dor");
      check("t1_data", data_out, word(10'(i)));
      check("t1_pc", {16'b0, pc_out}, 32'(4 * i));
      ack_on();
      if (i == 2) run = 1'b0;
      tick(5);
      ack_from_next = 1'b0;
    end
    tick(3);
    check("t1_cnt", {16'b0, fetch_count}, 32'd3);
    check("t1_pc_end", {16'b0, pc_out}, 32'h000C);
    check("t1_idle", {30'b0, mem_en, DOR}, 32'd0);

    // latency 4
    lat = 4;
    run = 1'b1;
    wait_memen("t2_en");
    for (int j = 0; j < 4; j++) begin
      check("t2_hold", {20'b0, mem_en, mem_do_ack, mem_addr},
            {20'b0, 1'b1, 1'b0, 10'd3});
      tick(1);
    end
    check("t2_ack", {30'b0, mem_en, mem_do_ack}, 32'd3);
    tick(1);
    check("t2_dor", {30'b0, DOR, mem_en}, 32'd2);
    check("t2_data", data_out, word(10'd3));
    ack_on();
    run = 1'b0;
    tick(2);
    ack_from_next = 1'b0;
    tick(2);

    // redirect in IDLE, then in WAIT_MEM
    redirect_en = 1'b1;
    redirect_pc = 16'h0008;
    tick(1);
    redirect_en = 1'b0;
    check("t3_idle_redir", {16'b0, pc_out}, 32'h0008);
    lat = 3;
    run = 1'b1;
    wait_memen("t3_en");
    check("t3_addr_old", {22'b0, mem_addr}, 32'h002);
    redirect_en = 1'b1;
    redirect_pc = 16'h0103;
    tick(1);
    redirect_en = 1'b0;
    check("t3_pc", {16'b0, pc_out}, 32'h0100);
    wait_dor("t3_dor");
    run = 1'b0;
    check("t3_data", data_out, word(10'h040));
    check("t3_addr", {22'b0, last_addr}, 32'h040);

    // redirect in PRESENT without ack
    redirect_en = 1'b1;
    redirect_pc = 16'h0200;
    tick(1);
    redirect_en = 1'b0;
    check("t4_dor", {31'b0, DOR}, 32'd0);
    check("t4_cnt", {16'b0, fetch_count}, 32'd4);
    wait_dor("t4_dor2");
    check("t4_data", data_out, word(10'h080));

    // redirect coincident with ack
    ack_from_next = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 16'hFFFC;
    tick(1);
    redirect_en = 1'b0;
    check("t4_cnt2", {16'b0, fetch_count}, 32'd5);
    check("t4_pc2", {16'b0, pc_out}, 32'hFFFC);
    run = 1'b1;
    tick(2);
    ack_from_next = 1'b0;
    wait_dor("t5_dor");
    check("t5_data", data_out, word(10'h3FF));
    check("t5_pc", {16'b0, pc_out}, 32'hFFFC);
    run = 1'b0;
    ack_on();
    check("t5_wrap", {16'b0, pc_out}, 32'h0000);
    check("t5_cnt", {16'b0, fetch_count}, 32'd6);
    tick(2);
    ack_from_next = 1'b0;
    tick(4);
    check("t5_idle", {30'b0, mem_en, DOR}, 32'd0);

    // fetch from wrapped PC, then reset mid WAIT_MEM
    lat = 6;
    run = 1'b1;
    wait_memen("t6_en");
    check("t6_addr", {22'b0, mem_addr}, 32'h000);
    check("t6_pc", {16'b0, pc_out}, 32'h0000);
    run = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_rst_en", {31'b0, mem_en}, 32'd0);
    check("t6_rst_cnt", {16'b0, fetch_count}, 32'd0);
    check("t6_rst_out", {20'b0, DOR, mem_en, mem_addr}, 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
    force_ack = 1'b1;
    tick(1);
    force_ack = 1'b0;
    tick(2);
    check("t6_late_ack", {30'b0, DOR, mem_en}, 32'd0);

    check("dor_vs_ack", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
